// File: rtl/proximity_alert_engine.sv
// Multi-channel proximity alert: sequential nearest-distance scan, FAR/WARN/ALARM zoning
// with hysteresis, and glitch-free buzzer tone, LED PWM and display flash drive.
module proximity_alert_engine #(
   parameter int CHANNELS   = 4,
   parameter int DIST_WIDTH = 13,
   parameter int WARN_DIST  = 2000,
   parameter int ALARM_DIST = 500,
   parameter int HYST       = 50,
   parameter int TONE_SHIFT = 0,
   parameter int DIV_MIN    = 40,
   parameter int DIV_MAX    = 2040,
   parameter int PWM_PERIOD = 4096,
   parameter int LED_SHIFT  = 0,
   parameter int FLASH_DIV  = 12500000
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [CHANNELS*DIST_WIDTH-1:0] distance_in,
   input  logic                           valid_in,
   input  logic                           mute,
   output logic                           busy,
   output logic                           tone_out,
   output logic                           led_pwm,
   output logic                           flash_en,
   output logic [1:0]                     state_out,
   output logic [$clog2(CHANNELS)-1:0]    nearest_ch,
   output logic [DIST_WIDTH-1:0]          nearest_dist
);

   localparam int CH_W = $clog2(CHANNELS);
   localparam int XW   = DIST_WIDTH + 1;
   localparam int HW   = $clog2(DIV_MAX + 1);
   localparam int PW   = $clog2(PWM_PERIOD);
   localparam int DW   = PW + 1;
   localparam int FW   = $clog2(FLASH_DIV + 1);

   localparam logic [1:0] ST_FAR   = 2'b00;
   localparam logic [1:0] ST_WARN  = 2'b01;
   localparam logic [1:0] ST_ALARM = 2'b10;

   // One extra bit so threshold + HYST never wraps.
   localparam logic [XW-1:0] WARN_ENTER  = XW'(WARN_DIST);
   localparam logic [XW-1:0] ALARM_ENTER = XW'(ALARM_DIST);
   localparam logic [XW-1:0] WARN_EXIT   = XW'(WARN_DIST + HYST);
   localparam logic [XW-1:0] ALARM_EXIT  = XW'(ALARM_DIST + HYST);

   function automatic logic [1:0] zone_next(input logic [1:0] cur, input logic [DIST_WIDTH-1:0] d);
      logic [XW-1:0] dx;
      dx = {1'b0, d};
      zone_next = cur;
      case (cur)
         ST_FAR: begin
            if (dx < ALARM_ENTER)     zone_next = ST_ALARM;
            else if (dx < WARN_ENTER) zone_next = ST_WARN;
         end
         ST_WARN: begin
            if (dx < ALARM_ENTER)     zone_next = ST_ALARM;
            else if (dx >= WARN_EXIT) zone_next = ST_FAR;
         end
         ST_ALARM: begin
            if (dx >= WARN_EXIT)       zone_next = ST_FAR;
            else if (dx >= ALARM_EXIT) zone_next = ST_WARN;
         end
         default: zone_next = ST_FAR;
      endcase
   endfunction

   function automatic logic [HW-1:0] tone_half(input logic [DIST_WIDTH-1:0] d);
      logic [31:0] s;
      s = 32'(d >> TONE_SHIFT);
      if (s < 32'(DIV_MIN))      s = 32'(DIV_MIN);
      else if (s > 32'(DIV_MAX)) s = 32'(DIV_MAX);
      return HW'(s);
   endfunction

   function automatic logic [DW-1:0] led_duty(input logic [DIST_WIDTH-1:0] d);
      logic [31:0] s;
      s = 32'(d >> LED_SHIFT);
      if (s > 32'(PWM_PERIOD)) s = 32'(PWM_PERIOD);
      return DW'(32'(PWM_PERIOD) - s);
   endfunction

   logic [DIST_WIDTH-1:0] snap [CHANNELS];
   logic [CH_W-1:0]       idx, best_ch, cand_ch;
   logic [DIST_WIDTH-1:0] best_dist, cur_dist, cand_dist;
   logic                  scan_last;
   logic [1:0]            state;

   assign state_out = state;

   always_comb begin
      cur_dist  = snap[idx];
      scan_last = (idx == CH_W'(CHANNELS - 1));
      cand_ch   = best_ch;
      cand_dist = best_dist;
      if (cur_dist < best_dist) begin
         cand_ch   = idx;
         cand_dist = cur_dist;
      end
   end

   always_ff @(posedge clk) begin
      if (valid_in && !busy) begin
         for (int k = 0; k < CHANNELS; k++)
            snap[k] <= distance_in[k*DIST_WIDTH +: DIST_WIDTH];
      end
   end

   // Scan control: one compare per cycle, outputs and zone commit on the last compare.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy         <= 1'b0;
         idx          <= '0;
         best_ch      <= '0;
         best_dist    <= '1;
         nearest_ch   <= '0;
         nearest_dist <= '1;
         state        <= ST_FAR;
      end else if (busy) begin
         if (scan_last) begin
            busy         <= 1'b0;
            nearest_ch   <= cand_ch;
            nearest_dist <= cand_dist;
            state        <= zone_next(state, cand_dist);
         end else begin
            idx       <= idx + CH_W'(1);
            best_ch   <= cand_ch;
            best_dist <= cand_dist;
         end
      end else if (valid_in) begin
         busy      <= 1'b1;
         idx       <= '0;
         best_ch   <= '0;
         best_dist <= '1;
      end
   end

   logic [HW-1:0] h_target, h_cur, tone_cnt;
   logic          tone_run, tone_active;

   always_comb begin
      h_target    = (state == ST_ALARM) ? HW'(DIV_MIN) : tone_half(nearest_dist);
      tone_active = (state != ST_FAR) && !mute;
   end

   // Half-period only reloads at a toggle; restart begins with a full high phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         tone_out <= 1'b0;
         tone_cnt <= '0;
         tone_run <= 1'b0;
         h_cur    <= HW'(DIV_MIN);
      end else if (!tone_active) begin
         tone_out <= 1'b0;
         tone_cnt <= '0;
         tone_run <= 1'b0;
      end else if (!tone_run) begin
         tone_run <= 1'b1;
         tone_out <= 1'b1;
         tone_cnt <= '0;
         h_cur    <= h_target;
      end else if (tone_cnt == h_cur - HW'(1)) begin
         tone_out <= ~tone_out;
         tone_cnt <= '0;
         h_cur    <= h_target;
      end else begin
         tone_cnt <= tone_cnt + HW'(1);
      end
   end

   logic [PW-1:0] pwm_cnt;
   logic [DW-1:0] duty_latched;

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt      <= '0;
         duty_latched <= '0;
         led_pwm      <= 1'b0;
      end else begin
         if (pwm_cnt == PW'(PWM_PERIOD - 1)) begin
            pwm_cnt      <= '0;
            duty_latched <= led_duty(nearest_dist);
         end else begin
            pwm_cnt <= pwm_cnt + PW'(1);
         end
         led_pwm <= (state != ST_FAR) && ({1'b0, pwm_cnt} < duty_latched);
      end
   end

   logic [FW-1:0] flash_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         flash_en  <= 1'b1;
         flash_cnt <= '0;
      end else if (state != ST_ALARM) begin
         flash_en  <= 1'b1;
         flash_cnt <= '0;
      end else if (flash_cnt == FW'(FLASH_DIV - 1)) begin
         flash_en  <= ~flash_en;
         flash_cnt <= '0;
      end else begin
         flash_cnt <= flash_cnt + FW'(1);
      end
   end

endmodule

// File: tb/tb_proximity_alert_engine.sv
// Directed bench for proximity_alert_engine: scan latency, zoning, tone, PWM and flash.
module tb_proximity_alert_engine;

   localparam int CH  = 4;
   localparam int DWD = 13;

   logic              clk = 1'b0;
   logic              reset;
   logic [CH*DWD-1:0] distance_in;
   logic              valid_in;
   logic              mute;
   logic              busy, tone_out, led_pwm, flash_en;
   logic [1:0]        state_out;
   logic [1:0]        nearest_ch;
   logic [DWD-1:0]    nearest_dist;

   proximity_alert_engine #(.FLASH_DIV(16)) dut (
      .clk(clk), .reset(reset), .distance_in(distance_in), .valid_in(valid_in),
      .mute(mute), .busy(busy), .tone_out(tone_out), .led_pwm(led_pwm),
      .flash_en(flash_en), .state_out(state_out), .nearest_ch(nearest_ch),
      .nearest_dist(nearest_dist)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Edge monitors: phase lengths in clocks between successive output toggles.
   int   cyc = 0;
   logic tone_prev = 1'b0, flash_prev = 1'b1;
   int   tone_toggles = 0, tone_last = 0, tone_len = 0;
   int   flash_toggles = 0, flash_last = 0, flash_len = 0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (tone_out !== tone_prev) begin
         tone_toggles = tone_toggles + 1;
         tone_len     = cyc - tone_last;
         tone_last    = cyc;
         tone_prev    = tone_out;
      end
      if (flash_en !== flash_prev) begin
         flash_toggles = flash_toggles + 1;
         flash_len     = cyc - flash_last;
         flash_last    = cyc;
         flash_prev    = flash_en;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_scan(input int d0, input int d1, input int d2, input int d3);
      distance_in = {DWD'(d3), DWD'(d2), DWD'(d1), DWD'(d0)};
      valid_in    = 1'b1;
      tick(1);
      valid_in    = 1'b0;
   endtask

   task automatic scan(input int d0, input int d1, input int d2, input int d3);
      start_scan(d0, d1, d2, d3);
      tick(3);
      chk("scan_busy", busy, 1);
      tick(1);
   endtask

   task automatic wait_tone(input int n, input int budget);
      int start, c;
      start = tone_toggles;
      c = 0;
      while ((tone_toggles - start) < n && c < budget) begin
         tick(1);
         c++;
      end
      if ((tone_toggles - start) < n) chk("tone_wait", tone_toggles - start, n);
   endtask

   task automatic wait_flash(input int n, input int budget);
      int start, c;
      start = flash_toggles;
      c = 0;
      while ((flash_toggles - start) < n && c < budget) begin
         tick(1);
         c++;
      end
      if ((flash_toggles - start) < n) chk("flash_wait", flash_toggles - start, n);
   endtask

   task automatic count_led(input int n, output int highs);
      highs = 0;
      repeat (n) begin
         tick(1);
         if (led_pwm === 1'b1) highs++;
      end
   endtask

   initial begin
      int h, f0, th;
      reset = 1'b1; valid_in = 1'b0; mute = 1'b0; distance_in = '0;
      tick(3);
      reset = 1'b0;
      tick(1);
      chk("rst_busy",  busy, 0);
      chk("rst_tone",  tone_out, 0);
      chk("rst_led",   led_pwm, 0);
      chk("rst_flash", flash_en, 1);
      chk("rst_state", state_out, 0);
      chk("rst_ch",    nearest_ch, 0);
      chk("rst_dist",  nearest_dist, 8191);

      // Reset held for 3 cycles in the middle of a scan
      start_scan(100, 100, 100, 100);
      tick(1);
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(8);
      chk("abort_busy",  busy, 0);
      chk("abort_state", state_out, 0);
      chk("abort_dist",  nearest_dist, 8191);
      chk("abort_tone",  tone_out, 0);
      chk("abort_led",   led_pwm, 0);
      chk("abort_flash", flash_en, 1);

      // Tie between channels 1 and 2 resolves to 1; 1200 enters WARN
      start_scan(3000, 1200, 1200, 4000);
      tick(3);
      chk("lat_dist_old", nearest_dist, 8191);
      chk("lat_state_old", state_out, 0);
      tick(1);
      chk("warn_ch",    nearest_ch, 1);
      chk("warn_dist",  nearest_dist, 1200);
      chk("warn_state", state_out, 1);
      chk("warn_busy",  busy, 0);
      wait_tone(2, 3000);
      chk("warn_tone_high", tone_len, 1200);
      wait_tone(1, 3000);
      chk("warn_tone_low", tone_len, 1200);
      tick(4096);
      count_led(4096, h);
      chk("warn_led_duty", h, 2896);

      // Exit hysteresis from WARN
      scan(2020, 3000, 3000, 3000);
      chk("hyst_stay_state", state_out, 1);
      chk("hyst_stay_dist", nearest_dist, 2020);
      scan(5000, 2050, 6000, 7000);
      chk("hyst_far_state", state_out, 0);
      chk("hyst_far_ch", nearest_ch, 1);
      tick(1);
      chk("far_tone_off", tone_out, 0);
      chk("far_led_off", led_pwm, 0);

      // ALARM zone with flash toggling every 16 clocks
      scan(400, 900, 800, 3000);
      chk("alarm_state", state_out, 2);
      chk("alarm_flash_entry", flash_en, 1);
      wait_tone(2, 200);
      chk("alarm_tone_half", tone_len, 40);
      wait_flash(2, 100);
      chk("alarm_flash_half", flash_len, 16);
      scan(600, 520, 700, 900);
      chk("alarm_hold_state", state_out, 2);
      chk("alarm_hold_dist", nearest_dist, 520);
      scan(550, 600, 3000, 4000);
      chk("alarm_exit_state", state_out, 1);
      tick(1);
      chk("alarm_exit_flash", flash_en, 1);
      tick(1);
      f0 = flash_toggles;
      tick(20);
      chk("warn_flash_steady", flash_toggles - f0, 0);

      // Half-period change lands only at a toggle boundary
      scan(1000, 3000, 3000, 3000);
      chk("glitch_dist", nearest_dist, 1000);
      wait_tone(3, 4000);
      chk("glitch_settle", tone_len, 1000);
      tick(100);
      scan(1500, 3000, 3000, 3000);
      chk("glitch_dist2", nearest_dist, 1500);
      wait_tone(1, 2000);
      chk("glitch_cur_phase", tone_len, 1000);
      wait_tone(1, 2000);
      chk("glitch_next_phase", tone_len, 1500);

      // Mute in ALARM silences only the tone
      scan(300, 3000, 3000, 3000);
      chk("mute_state", state_out, 2);
      mute = 1'b1;
      tick(2);
      chk("mute_tone", tone_out, 0);
      f0 = flash_toggles;
      th = 0;
      repeat (100) begin
         tick(1);
         if (tone_out !== 1'b0) th++;
      end
      chk("mute_tone_quiet", th, 0);
      chk("mute_flash_running", (flash_toggles - f0) >= 6, 1);
      tick(4096);
      count_led(4096, h);
      chk("mute_led_duty", h, 3796);

      // A second valid_in during a scan is dropped
      start_scan(800, 700, 900, 1000);
      tick(1);
      distance_in = {DWD'(100), DWD'(100), DWD'(100), DWD'(100)};
      valid_in = 1'b1;
      tick(1);
      valid_in = 1'b0;
      tick(1);
      chk("dup_busy", busy, 1);
      chk("dup_dist_old", nearest_dist, 300);
      tick(1);
      chk("dup_ch", nearest_ch, 1);
      chk("dup_dist", nearest_dist, 700);
      chk("dup_state", state_out, 1);
      chk("dup_busy_done", busy, 0);
      tick(10);
      chk("dup_no_second_dist", nearest_dist, 700);
      chk("dup_no_second_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
